// File: rtl/tpu_pkg.sv
// Shared encodings for the TPU load controller: opcodes, FSM states and
// target-buffer selects.
package tpu_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_FETCH_W   = 3'b001,
        OP_FETCH_INP = 3'b010,
        OP_FETCH_INS = 3'b011,
        OP_START     = 3'b101
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_INP,
        ST_LOAD_INS,
        ST_RUN
    } state_e;

    // Select values double as the bit index into the loaded flags {ins, inp, w}.
    typedef enum logic [1:0] {
        SEL_W   = 2'b00,
        SEL_INP = 2'b01,
        SEL_INS = 2'b10
    } mem_sel_e;

endpackage

// File: rtl/tpu_load_ctrl_if.sv
// Host command/data stream and buffer write port of the TPU load controller.
interface tpu_load_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic [7:0]        data_in;
    logic              data_valid;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output cmd, cmd_valid, data_in, data_valid,
        input  mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd, cmd_valid, data_in, data_valid,
        output mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/tpu_beat_counter.sv
// Beat counter for buffer loads: synchronous clear, increment per beat and
// terminal-count flag against a run-time limit (index of the final beat).
module tpu_beat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = inc && (count_q == limit);
endmodule

// File: rtl/tpu_load_ctrl.sv
// TPU load controller: streams weight/input/instruction bytes into their
// buffers, tracks which buffers are loaded and launches the compute core.
module tpu_load_ctrl
    import tpu_pkg::*;
#(
    parameter int W_BYTES   = 4,
    parameter int INP_BYTES = 4,
    parameter int INS_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    tpu_load_ctrl_if.slave        bus,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  core_start,
    output logic [2:0]            loaded,
    output logic                  done,
    output logic                  err
);
    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(W_BYTES - 1);
    localparam logic [ADDR_W-1:0] INP_LAST = ADDR_W'(INP_BYTES - 1);
    localparam logic [ADDR_W-1:0] INS_LAST = ADDR_W'(INS_BYTES - 1);

    state_e            state_q,      state_d;
    logic [2:0]        loaded_q,     loaded_d;
    logic              busy_q,       busy_d;
    logic              mem_we_q,     mem_we_d;
    mem_sel_e          mem_sel_q,    mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [7:0]        mem_wdata_q,  mem_wdata_d;
    logic              core_start_q, core_start_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;

    logic              cnt_clear;
    logic              cnt_inc;
    logic              cnt_last;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_limit;
    mem_sel_e          load_sel;

    tpu_beat_counter #(
        .CNT_W (ADDR_W)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .count (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        load_sel  = SEL_W;
        cnt_limit = W_LAST;
        case (state_q)
            ST_LOAD_INP: begin
                load_sel  = SEL_INP;
                cnt_limit = INP_LAST;
            end
            ST_LOAD_INS: begin
                load_sel  = SEL_INS;
                cnt_limit = INS_LAST;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        mem_we_d     = 1'b0;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (opcode_e'(bus.cmd))
                        OP_FETCH_W: begin
                            state_d           = ST_LOAD_W;
                            cnt_clear         = 1'b1;
                            loaded_d[SEL_W]   = 1'b0;
                        end
                        OP_FETCH_INP: begin
                            state_d           = ST_LOAD_INP;
                            cnt_clear         = 1'b1;
                            loaded_d[SEL_INP] = 1'b0;
                        end
                        OP_FETCH_INS: begin
                            state_d           = ST_LOAD_INS;
                            cnt_clear         = 1'b1;
                            loaded_d[SEL_INS] = 1'b0;
                        end
                        OP_START: begin
                            if (loaded_q == 3'b111) begin
                                state_d      = ST_RUN;
                                core_start_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_NOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD_W, ST_LOAD_INP, ST_LOAD_INS: begin
                // Commands are refused here, but a beat on the same cycle still lands.
                err_d = bus.cmd_valid;
                if (bus.data_valid) begin
                    cnt_inc     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_sel_d   = load_sel;
                    mem_addr_d  = cnt;
                    mem_wdata_d = bus.data_in;
                    if (cnt_last) begin
                        state_d            = ST_IDLE;
                        loaded_d[load_sel] = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                err_d = bus.cmd_valid;
                if (core_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            loaded_q     <= '0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= SEL_W;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign core_start    = core_start_q;
    assign loaded        = loaded_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_tpu_load_ctrl.sv
// Bench for tpu_load_ctrl: directed scenarios, a per-cycle behavioural model
// check and literal expectations on the captured write stream.
module tb_tpu_load_ctrl;
    logic       clk;
    logic       reset;
    logic       core_done;
    logic       busy;
    logic       core_start;
    logic [2:0] loaded;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    tpu_load_ctrl_if #(.ADDR_W(4)) bus ();

    tpu_load_ctrl #(
        .W_BYTES   (4),
        .INP_BYTES (4),
        .INS_BYTES (16),
        .ADDR_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_done  (core_done),
        .busy       (busy),
        .core_start (core_start),
        .loaded     (loaded),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1..3 loading buffer (mode-1), 4 running.
    int         mode;
    int         cnt;
    int         nbytes [3] = '{4, 4, 16};
    logic [2:0] m_loaded;
    logic       e_busy, e_we, e_start, e_done, e_err;
    logic [1:0] e_sel;
    logic [3:0] e_addr;
    logic [7:0] e_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode = 0; cnt = 0; m_loaded = 3'b000;
            e_busy = 0; e_we = 0; e_start = 0; e_done = 0; e_err = 0;
            e_sel = 0; e_addr = 0; e_data = 0;
        end else begin
            e_we = 0; e_start = 0; e_done = 0; e_err = 0;
            if (mode == 0) begin
                if (bus.cmd_valid) begin
                    if (bus.cmd == 3'd1 || bus.cmd == 3'd2 || bus.cmd == 3'd3) begin
                        mode = int'(bus.cmd);
                        cnt = 0;
                        m_loaded[mode-1] = 1'b0;
                    end else if (bus.cmd == 3'd5) begin
                        if (m_loaded == 3'b111) begin
                            mode = 4;
                            e_start = 1;
                        end else begin
                            e_err = 1;
                        end
                    end else if (bus.cmd != 3'd0) begin
                        e_err = 1;
                    end
                end
            end else begin
                e_err = bus.cmd_valid;
                if (mode < 4) begin
                    if (bus.data_valid) begin
                        e_we = 1;
                        e_sel = 2'(mode - 1);
                        e_addr = 4'(cnt);
                        e_data = bus.data_in;
                        cnt++;
                        if (cnt == nbytes[mode-1]) begin
                            m_loaded[mode-1] = 1'b1;
                            mode = 0;
                        end
                    end
                end else if (core_done) begin
                    mode = 0;
                    e_done = 1;
                end
            end
            e_busy = (mode != 0);
        end
    end

    always @(negedge clk) begin
        logic [21:0] act, exp;
        act = {busy, bus.mem_we, 14'd0, core_start, loaded, done, err};
        exp = {e_busy, e_we, 14'd0, e_start, m_loaded, e_done, e_err};
        if (e_we) begin
            act[19:6] = {bus.mem_sel, bus.mem_addr, bus.mem_wdata};
            exp[19:6] = {e_sel, e_addr, e_data};
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
        end
    end

    logic [13:0] wlog [$];
    always @(posedge clk) begin
        #1;
        if (bus.mem_we === 1'b1) wlog.push_back({bus.mem_sel, bus.mem_addr, bus.mem_wdata});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic cv, input logic [2:0] c, input logic dv, input logic [7:0] d);
        bus.cmd_valid = cv; bus.cmd = c; bus.data_valid = dv; bus.data_in = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    initial begin
        int base;
        logic [7:0] inp_data [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

        reset = 1'b1; core_done = 1'b0;
        bus.cmd = 3'd0; bus.cmd_valid = 1'b0; bus.data_in = 8'h00; bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {busy, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, core_start, loaded, done, err},
            32'd0);
        reset = 1'b0;

        // Weights, accepted on the first edge after reset release.
        step(1'b1, 3'b001, 1'b0, 8'h00);
        chk("fetch_w_busy", busy, 1);
        step(1'b0, 3'd0, 1'b1, 8'h11);
        step(1'b0, 3'd0, 1'b1, 8'h22);
        step(1'b0, 3'd0, 1'b1, 8'h33);
        step(1'b0, 3'd0, 1'b1, 8'h44);
        chk("w_last_busy", busy, 0);
        chk("w_loaded", loaded, 3'b001);
        chk("w_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("w_write%0d", i), wlog[i], {2'b00, 4'(i), 8'(8'h11 * (i + 1))});
        idle(1);

        // Inputs with gaps in the beat stream.
        base = wlog.size();
        step(1'b1, 3'b010, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, inp_data[0]);
        idle(3);
        step(1'b0, 3'd0, 1'b1, inp_data[1]);
        step(1'b0, 3'd0, 1'b1, inp_data[2]);
        idle(1);
        step(1'b0, 3'd0, 1'b1, inp_data[3]);
        idle(1);
        chk("inp_nwrites", wlog.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("inp_write%0d", i), wlog[base+i], {2'b01, 4'(i), inp_data[i]});
        chk("inp_loaded", loaded, 3'b011);

        // START refused while instructions are missing.
        step(1'b1, 3'b101, 1'b0, 8'h00);
        chk("start_early_err", {err, core_start, busy}, 3'b100);
        idle(1);
        chk("start_early_err_pulse", err, 0);

        // Illegal opcode, NOP and stray data in IDLE.
        step(1'b1, 3'b110, 1'b0, 8'h00);
        chk("illegal_err", err, 1);
        step(1'b1, 3'b000, 1'b0, 8'h00);
        chk("nop_no_err", err, 0);
        step(1'b0, 3'd0, 1'b1, 8'hEE);
        chk("idle_data_no_we", bus.mem_we, 0);

        // Instructions: command collisions on beat 5 and on the final beat.
        base = wlog.size();
        step(1'b1, 3'b011, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (i == 5)       step(1'b1, 3'b001, 1'b1, 8'(8'hC0 + i));
            else if (i == 15) step(1'b1, 3'b101, 1'b1, 8'(8'hC0 + i));
            else              step(1'b0, 3'd0,   1'b1, 8'(8'hC0 + i));
            if (i == 5) chk("ins_beat5_collision", {err, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 4'd5, 8'hC5});
        end
        chk("ins_last_collision", {err, core_start, busy, loaded}, {3'b100, 3'b111});
        chk("ins_nwrites", wlog.size() - base, 16);
        idle(1);

        // Run.
        step(1'b1, 3'b101, 1'b0, 8'h00);
        chk("start_pulse", {core_start, busy, err}, 3'b110);
        step(1'b1, 3'b001, 1'b1, 8'h99);
        chk("run_cmd_err", {core_start, err, bus.mem_we}, 3'b010);
        idle(2);
        core_done = 1'b1;
        step(1'b0, 3'd0, 1'b0, 8'h00);
        core_done = 1'b0;
        chk("run_done", {done, busy, loaded}, {2'b10, 3'b111});
        idle(1);
        chk("done_pulse_end", done, 0);
        core_done = 1'b1;
        step(1'b0, 3'd0, 1'b0, 8'h00);
        core_done = 1'b0;
        chk("idle_core_done_ignored", done, 0);

        // Re-fetch weights, then reset mid-load.
        step(1'b1, 3'b001, 1'b0, 8'h00);
        chk("refetch_clears_w", loaded, 3'b110);
        step(1'b0, 3'd0, 1'b1, 8'h55);
        step(1'b0, 3'd0, 1'b1, 8'h66);
        base = wlog.size();
        bus.data_valid = 1'b1; bus.data_in = 8'h77;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {busy, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, core_start, loaded, done, err},
            32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 3'd0, 1'b1, 8'h78);
        idle(1);
        chk("reset_no_writes", wlog.size() - base, 0);
        step(1'b1, 3'b001, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, 8'(8'h81 + i));
        chk("restart_nwrites", wlog.size() - base, 4);
        chk("restart_first", wlog[base], {2'b00, 4'd0, 8'h81});
        chk("restart_loaded", loaded, 3'b001);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
